// File: rtl/vga_color_index_gen.sv
// VGA raster timing plus a scrolling vertical-bar colour index for the palette LUT.
// All outputs are registered and describe the pixel at (x, y).
module vga_color_index_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BAR_WIDTH  = 40,
  parameter int SCROLL_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       scroll_en,
  output logic [3:0] color_index,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW_W    = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam int FC_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [BW_W-1:0] BAR_LAST = BW_W'(BAR_WIDTH - 1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(SCROLL_DIV - 1);

  // Position and pattern state
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [BW_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [3:0]      bar_idx_q, bar_idx_d;
  logic [3:0]      offset_q, offset_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  // Output registers
  logic [3:0] color_index_q, color_index_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       frame_start_q, frame_start_d;

  logic line_end;
  logic frame_end;

  assign line_end  = (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    offset_d  = offset_q;
    fcnt_d    = fcnt_q;

    if (pix_en) begin
      if (line_end) begin
        x_d       = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        y_d       = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 4'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end

      // Offset only moves across the frame wrap, so it is constant for a whole frame.
      if (frame_end && scroll_en) begin
        if (fcnt_q == FC_LAST) begin
          fcnt_d   = '0;
          offset_d = offset_q + 4'd1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next position so they line up with x/y.
  always_comb begin
    de_d          = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    color_index_d = de_d ? (bar_idx_d + offset_d) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      offset_q      <= '0;
      fcnt_q        <= '0;
      color_index_q <= 4'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      offset_q      <= offset_d;
      fcnt_q        <= fcnt_d;
      color_index_q <= color_index_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign color_index = color_index_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;

endmodule
